// File: rtl/qic117_step_encoder_if.sv
// Command handshake between the tape-control sequencer and the QIC-117 STEP encoder.
interface qic117_step_encoder_if;
  logic [5:0] cmd_code;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       abort;
  logic       busy;
  logic [5:0] pulses_sent;
  logic       cmd_done;
  logic       cmd_aborted;
  logic       cmd_reject;

  // Sequencer side: offers commands and may cancel them.
  modport master (
    output cmd_code, cmd_valid, abort,
    input  cmd_ready, busy, pulses_sent, cmd_done, cmd_aborted, cmd_reject
  );

  // Encoder side: accepts commands and reports progress.
  modport slave (
    input  cmd_code, cmd_valid, abort,
    output cmd_ready, busy, pulses_sent, cmd_done, cmd_aborted, cmd_reject
  );
endinterface

// File: rtl/qic117_step_encoder.sv
// Host-side QIC-117 command transmitter: a command code N becomes N STEP pulses
// at a fixed rate, followed by a quiet guard gap longer than the drive's
// command-complete timeout.
module qic117_step_encoder #(
  parameter int STEP_PULSE_CYC  = 100,
  parameter int STEP_PERIOD_CYC = 150000,
  parameter int CMD_GAP_CYC     = 5500000,
  parameter int CNT_W           = 23
) (
  input  logic                    clk,
  input  logic                    reset,
  qic117_step_encoder_if.slave    bus,
  output logic                    step_out
);

  typedef enum logic [1:0] {
    IDLE,
    PULSE_HI,
    PULSE_LO,
    GAP
  } state_t;

  // Timers count down to zero, so each load is one less than the state's length.
  localparam logic [CNT_W-1:0] HI_LOAD  = CNT_W'(STEP_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] LO_LOAD  = CNT_W'(STEP_PERIOD_CYC - STEP_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(CMD_GAP_CYC - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  state_t           state, state_next;
  logic [CNT_W-1:0] timer, timer_next;
  logic [5:0]       remaining, remaining_next;
  logic [5:0]       pulses, pulses_next;
  logic             aborted_flag, aborted_flag_next;
  logic             done_next, aborted_pulse_next, reject_next;
  logic             done_q, aborted_q, reject_q;
  logic             code_ok;

  assign code_ok = (bus.cmd_code != 6'd0) && (bus.cmd_code <= 6'd48);

  // Next-state, timer and bookkeeping decisions for the pulse sequencer.
  always_comb begin
    state_next         = state;
    timer_next         = timer;
    remaining_next     = remaining;
    pulses_next        = pulses;
    aborted_flag_next  = aborted_flag;
    done_next          = 1'b0;
    aborted_pulse_next = 1'b0;
    reject_next        = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          if (code_ok) begin
            state_next        = PULSE_HI;
            timer_next        = HI_LOAD;
            remaining_next    = bus.cmd_code;
            pulses_next       = 6'd1;
            aborted_flag_next = 1'b0;
          end else begin
            reject_next = 1'b1;
          end
        end
      end
      PULSE_HI: begin
        if (bus.abort) begin
          state_next        = GAP;
          timer_next        = GAP_LOAD;
          aborted_flag_next = 1'b1;
        end else if (timer == '0) begin
          state_next = PULSE_LO;
          timer_next = LO_LOAD;
        end else begin
          timer_next = timer - ONE;
        end
      end
      PULSE_LO: begin
        if (bus.abort) begin
          state_next        = GAP;
          timer_next        = GAP_LOAD;
          aborted_flag_next = 1'b1;
        end else if (timer == '0) begin
          remaining_next = remaining - 6'd1;
          if (remaining > 6'd1) begin
            state_next  = PULSE_HI;
            timer_next  = HI_LOAD;
            pulses_next = pulses + 6'd1;
          end else begin
            state_next = GAP;
            timer_next = GAP_LOAD;
          end
        end else begin
          timer_next = timer - ONE;
        end
      end
      GAP: begin
        if (bus.abort) begin
          aborted_flag_next = 1'b1;
        end
        if (timer == '0) begin
          state_next         = IDLE;
          timer_next         = '0;
          done_next          = 1'b1;
          aborted_pulse_next = aborted_flag | bus.abort;
        end else begin
          timer_next = timer - ONE;
        end
      end
      default: begin
        state_next = IDLE;
        timer_next = '0;
      end
    endcase
  end

  // State register plus registered outputs; STEP is high exactly while in PULSE_HI.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      timer        <= '0;
      remaining    <= '0;
      pulses       <= '0;
      aborted_flag <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      reject_q     <= 1'b0;
      step_out     <= 1'b0;
    end else begin
      state        <= state_next;
      timer        <= timer_next;
      remaining    <= remaining_next;
      pulses       <= pulses_next;
      aborted_flag <= aborted_flag_next;
      done_q       <= done_next;
      aborted_q    <= aborted_pulse_next;
      reject_q     <= reject_next;
      step_out     <= (state_next == PULSE_HI);
    end
  end

  assign bus.cmd_ready   = (state == IDLE) && !reset;
  assign bus.busy        = (state != IDLE);
  assign bus.pulses_sent = pulses;
  assign bus.cmd_done    = done_q;
  assign bus.cmd_aborted = aborted_q;
  assign bus.cmd_reject  = reject_q;

endmodule
